twiddle_rotator144: RTL and testbench

TWIDDLE_ROTATOR144 -- requirements
Module: twiddle_rotator144

---
 rtl/fft144_pkg.sv | 32 +++
 rtl/cmult_rnd.sv | 110 +++++++++++
 rtl/twiddle_rotator144.sv | 109 ++++++++++
 tb/tb_twiddle_rotator144.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft144_pkg.sv
// Shared constants and types for the 144-point (12x12) FFT datapath.
//
// Contents:
//   N, N1, N2     transform size and its row/column factors
//   ADDR_W        twiddle ROM address width
//   TW_FRAC       fractional bits of the twiddle factors (unity = 1 << TW_FRAC)
//   RND           rounding constant added before the TW_FRAC-bit right shift
//   idx_state_t   column/row/address-accumulator state of the index sequencer
package fft144_pkg;

  localparam int N       = 144;
  localparam int N1      = 12;   // number of rows
  localparam int N2      = 12;   // number of columns
  localparam int ADDR_W  = 11;
  localparam int TW_FRAC = 10;
  localparam int RND     = 1 << (TW_FRAC - 1);

  localparam int COL_W = $clog2(N2);
  localparam int ROW_W = $clog2(N1);
  // r*c never exceeds (N1-1)*(N2-1) = 121, so log2(N) bits are plenty.
  localparam int ACC_W = $clog2(N);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N2 - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N1 - 1);

  typedef struct packed {
    logic [COL_W-1:0] c;    // column index
    logic [ROW_W-1:0] r;    // row index
    logic [ACC_W-1:0] acc;  // running r*c for the current sample
  } idx_state_t;

endpackage

// File: rtl/cmult_rnd.sv
// Two-stage registered complex multiplier with round-half-up and saturation.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   vld_i, tag_i           input valid and a sideband bit carried with it
//   a_re_i, a_im_i         data operand, WIDTH-bit signed
//   b_re_i, b_im_i         twiddle operand, TW_W-bit signed, TW_FRAC fraction bits
//   vld_o, tag_o           valid/sideband, two cycles after vld_i/tag_i
//   y_re_o, y_im_o         (a*b + RND) >>> TW_FRAC, saturated to WIDTH bits;
//                          hold their last value while vld_o is low
//
// Stage 1 registers the full-precision sums, stage 2 the rounded result.
module cmult_rnd
  import fft144_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TW_W  = 18
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    vld_i,
  input  logic                    tag_i,
  input  logic signed [WIDTH-1:0] a_re_i,
  input  logic signed [WIDTH-1:0] a_im_i,
  input  logic signed [TW_W-1:0]  b_re_i,
  input  logic signed [TW_W-1:0]  b_im_i,
  output logic                    vld_o,
  output logic                    tag_o,
  output logic signed [WIDTH-1:0] y_re_o,
  output logic signed [WIDTH-1:0] y_im_o
);

  localparam int PW  = WIDTH + TW_W;     // one product
  localparam int SW  = PW + 1;           // sum of two products
  localparam int SHW = SW - TW_FRAC;     // after dropping the fraction
  localparam logic signed [SW-1:0] RND_C = SW'(RND);

  logic signed [PW-1:0] a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] sum_re_d, sum_im_d, sum_re_q, sum_im_q;
  logic signed [SW-1:0] rnd_re, rnd_im;
  logic                 s2_vld_q, s2_tag_q;
  logic                 vld_q, tag_q;
  logic signed [WIDTH-1:0] y_re_d, y_im_d, y_re_q, y_im_q;

  // Sign-extend to the product width so the multiply is exact.
  assign a_re_x = PW'(a_re_i);
  assign a_im_x = PW'(a_im_i);
  assign b_re_x = PW'(b_re_i);
  assign b_im_x = PW'(b_im_i);

  assign p_rr = a_re_x * b_re_x;
  assign p_ii = a_im_x * b_im_x;
  assign p_ri = a_re_x * b_im_x;
  assign p_ir = a_im_x * b_re_x;

  assign sum_re_d = SW'(p_rr) - SW'(p_ii);
  assign sum_im_d = SW'(p_ri) + SW'(p_ir);

  // Upper bits beyond WIDTH must all equal the sign bit, otherwise clip.
  function automatic logic [WIDTH-1:0] sat(input logic [SHW-1:0] x);
    logic [SHW-WIDTH:0] top;
    top = x[SHW-1:WIDTH-1];
    if ((&top) || !(|top)) begin
      sat = x[WIDTH-1:0];
    end else if (x[SHW-1]) begin
      sat = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat = {1'b0, {(WIDTH-1){1'b1}}};
    end
  endfunction

  // Taking the upper slice of (sum + RND) is the arithmetic shift right.
  assign rnd_re = sum_re_q + RND_C;
  assign rnd_im = sum_im_q + RND_C;
  assign y_re_d = sat(rnd_re[SW-1:TW_FRAC]);
  assign y_im_d = sat(rnd_im[SW-1:TW_FRAC]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_vld_q <= 1'b0;
      s2_tag_q <= 1'b0;
      sum_re_q <= '0;
      sum_im_q <= '0;
      vld_q    <= 1'b0;
      tag_q    <= 1'b0;
      y_re_q   <= '0;
      y_im_q   <= '0;
    end else begin
      s2_vld_q <= vld_i;
      s2_tag_q <= vld_i & tag_i;
      if (vld_i) begin
        sum_re_q <= sum_re_d;
        sum_im_q <= sum_im_d;
      end
      vld_q <= s2_vld_q;
      tag_q <= s2_vld_q & s2_tag_q;
      if (s2_vld_q) begin
        y_re_q <= y_re_d;
        y_im_q <= y_im_d;
      end
    end
  end

  assign vld_o  = vld_q;
  assign tag_o  = tag_q;
  assign y_re_o = y_re_q;
  assign y_im_o = y_im_q;

endmodule

// File: rtl/twiddle_rotator144.sv
// Inter-stage twiddle rotation for a 144-point FFT built as 12x12.
// Sample i = 12*r + c is multiplied by W(r*c) fetched from an external
// registered twiddle ROM.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   di_en, di_re, di_im    input sample and its valid
//   frm_clr                synchronous frame restart (sample index -> 0)
//   tw_addr                ROM address for the sample presented this cycle
//   tw_re, tw_im           ROM data, one cycle after tw_addr
//   do_en, do_re, do_im    rotated sample and its valid (3 cycles after di_en)
//   do_sof                 marks the output of frame index 0
//
// Flow control: di_en and do_en are valid-only strobes with no ready; a
// sample is consumed on every rising edge where di_en is high, and any
// number of idle cycles may separate samples. do_re/do_im hold while do_en
// is low.
module twiddle_rotator144
  import fft144_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TW_W  = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    di_en,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  input  logic                    frm_clr,
  output logic [ADDR_W-1:0]       tw_addr,
  input  logic signed [TW_W-1:0]  tw_re,
  input  logic signed [TW_W-1:0]  tw_im,
  output logic                    do_en,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic                    do_sof
);

  idx_state_t idx_d, idx_q;
  logic       sof_t0;

  logic                    s1_en_q, s1_sof_q;
  logic signed [WIDTH-1:0] s1_re_q, s1_im_q;

  // Index sequencer. The accumulator adds r per column so it equals r*c
  // without a multiplier; it restarts when the column wraps.
  always_comb begin
    idx_d = idx_q;
    if (frm_clr) begin
      idx_d = '0;
      // A sample arriving with frm_clr is index 0, so the next one is 1.
      if (di_en) idx_d.c = COL_W'(1);
    end else if (di_en) begin
      if (idx_q.c == COL_LAST) begin
        idx_d.c   = '0;
        idx_d.acc = '0;
        idx_d.r   = (idx_q.r == ROW_LAST) ? '0 : idx_q.r + ROW_W'(1);
      end else begin
        idx_d.c   = idx_q.c + COL_W'(1);
        idx_d.acc = idx_q.acc + ACC_W'(idx_q.r);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  // frm_clr forces the current sample to index 0 in the same cycle.
  assign tw_addr = frm_clr ? '0 : ADDR_W'(idx_q.acc);
  assign sof_t0  = frm_clr | ((idx_q.c == '0) && (idx_q.r == '0));

  // Align data with the registered ROM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_en_q  <= 1'b0;
      s1_sof_q <= 1'b0;
      s1_re_q  <= '0;
      s1_im_q  <= '0;
    end else begin
      s1_en_q  <= di_en;
      s1_sof_q <= di_en & sof_t0;
      if (di_en) begin
        s1_re_q <= di_re;
        s1_im_q <= di_im;
      end
    end
  end

  cmult_rnd #(
    .WIDTH (WIDTH),
    .TW_W  (TW_W)
  ) u_cmult (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .vld_i  (s1_en_q),
    .tag_i  (s1_sof_q),
    .a_re_i (s1_re_q),
    .a_im_i (s1_im_q),
    .b_re_i (tw_re),
    .b_im_i (tw_im),
    .vld_o  (do_en),
    .tag_o  (do_sof),
    .y_re_o (do_re),
    .y_im_o (do_im)
  );

endmodule

// File: tb/tb_twiddle_rotator144.sv
// Bench for twiddle_rotator144: registered twiddle ROM model, table of
// hand-computed vectors over a gap-free two-frame run, a gapped rerun that
// must reproduce it, plus reset and frame-restart sequences.
module tb_twiddle_rotator144;

  localparam int WIDTH = 16;
  localparam int TW_W  = 18;
  localparam int NS    = 144;
  localparam int NTOT  = 288;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                    di_en = 1'b0;
  logic                    frm_clr = 1'b0;
  logic signed [WIDTH-1:0] di_re = '0;
  logic signed [WIDTH-1:0] di_im = '0;
  logic [10:0]             tw_addr;
  logic signed [TW_W-1:0]  tw_re = '0;
  logic signed [TW_W-1:0]  tw_im = '0;
  logic                    do_en, do_sof;
  logic signed [WIDTH-1:0] do_re, do_im;

  twiddle_rotator144 #(.WIDTH(WIDTH), .TW_W(TW_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .di_en   (di_en),
    .di_re   (di_re),
    .di_im   (di_im),
    .frm_clr (frm_clr),
    .tw_addr (tw_addr),
    .tw_re   (tw_re),
    .tw_im   (tw_im),
    .do_en   (do_en),
    .do_re   (do_re),
    .do_im   (do_im),
    .do_sof  (do_sof)
  );

  // ---------------- twiddle ROM model (registered) ----------------
  int rom_re[NS];
  int rom_im[NS];

  initial begin
    for (int k = 0; k < NS; k++) begin
      real ang, cr, ci;
      ang = 2.0 * 3.14159265358979 * k / 144.0;
      cr  = 1024.0 * $cos(ang);
      ci  = -1024.0 * $sin(ang);
      rom_re[k] = $rtoi(cr >= 0.0 ? cr + 0.5 : cr - 0.5);
      rom_im[k] = $rtoi(ci >= 0.0 ? ci + 0.5 : ci - 0.5);
    end
    // Entries as stored in the production table.
    rom_re[1]  = 1023; rom_im[1]  = -45;
    rom_re[18] = 724;  rom_im[18] = -725;
  end

  always @(posedge clk) begin
    if (tw_addr < 11'(NS)) begin
      tw_re <= TW_W'(rom_re[tw_addr]);
      tw_im <= TW_W'(rom_im[tw_addr]);
    end else begin
      tw_re <= '0;
      tw_im <= '0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
    logic                    sof;
  } out_t;

  out_t got_q[$];
  out_t ref_q[$];
  int   lat_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs sampled mid-cycle; each do_en must come 3 cycles after a di_en.
  int t_in;
  always @(negedge clk) begin
    if (!rst_n) begin
      lat_q.delete();
    end else begin
      if (do_en) begin
        got_q.push_back('{do_re, do_im, do_sof});
        t_in = (lat_q.size() != 0) ? lat_q.pop_front() : -1000;
        check("do_en_latency", cyc - t_in, 3);
      end
      if (di_en) lat_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_sample(input string name, input int re, input int im,
                              input logic clr, input int exp_addr);
    @(posedge clk); #1;
    di_en   = 1'b1;
    frm_clr = clr;
    di_re   = WIDTH'(re);
    di_im   = WIDTH'(im);
    if (exp_addr >= 0) begin
      #1;
      check(name, tw_addr, exp_addr);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      di_en   = 1'b0;
      frm_clr = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name, input int n);
    for (int k = 0; k < 400 && got_q.size() < n; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    check(name, got_q.size(), n);
  endtask

  function automatic int addr_of(input int s);
    int i;
    i = s % NS;
    return (i / 12) * (i % 12);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int idx;      // sample number in the two-frame run
    int in_re;
    int in_im;
    int exp_re;
    int exp_im;
  } vec_t;

  vec_t vecs[10];
  int   stim_re[NTOT];
  int   stim_im[NTOT];

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int nsof;

    vecs[0] = '{0,     1000,      0,   1000,      0};
    vecs[1] = '{5,     1000,      0,   1000,      0};
    vecs[2] = '{12,    1000,      0,   1000,      0};
    vecs[3] = '{13,    1000,      0,    999,    -44};
    vecs[4] = '{24,  -32768,  32767, -32768,  32767};
    vecs[5] = '{36,    -500,    300,   -500,    300};
    vecs[6] = '{42,   32767,  32767,  32767,    -32};
    vecs[7] = '{75,  -32768, -32768, -32768,     32};
    vecs[8] = '{157,      0,   1000,     44,    999};
    vecs[9] = '{177,  -1000,      0,   -707,    708};

    for (int s = 0; s < NTOT; s++) begin
      if (s < NS) begin
        stim_re[s] = 1000;
        stim_im[s] = 0;
      end else begin
        stim_re[s] = int'($urandom_range(65535, 0)) - 32768;
        stim_im[s] = int'($urandom_range(65535, 0)) - 32768;
      end
    end
    foreach (vecs[v]) begin
      stim_re[vecs[v].idx] = vecs[v].in_re;
      stim_im[vecs[v].idx] = vecs[v].in_im;
    end

    // ---- reset state ----
    #12;
    check("rst_tw_addr", tw_addr, 0);
    check("rst_do_en", do_en, 0);
    check("rst_do_sof", do_sof, 0);
    check("rst_do_re", do_re, 0);
    check("rst_do_im", do_im, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- two frames, gap-free ----
    for (int s = 0; s < NTOT; s++)
      drive_sample($sformatf("tw_addr_run1[%0d]", s), stim_re[s], stim_im[s], 1'b0, addr_of(s));
    idle(1);
    wait_drain("out_count_run1", NTOT);
    ref_q = got_q;

    foreach (vecs[v]) begin
      check($sformatf("re[%0d]", vecs[v].idx), ref_q[vecs[v].idx].re, vecs[v].exp_re);
      check($sformatf("im[%0d]", vecs[v].idx), ref_q[vecs[v].idx].im, vecs[v].exp_im);
      check($sformatf("sof[%0d]", vecs[v].idx), ref_q[vecs[v].idx].sof, (vecs[v].idx % NS) == 0);
    end
    for (int s = 0; s < NS; s++) begin
      if (s <= 12 && ref_q.size() > s)
        check($sformatf("unity_re[%0d]", s), ref_q[s].re, 1000);
    end
    nsof = 0;
    foreach (ref_q[k]) if (ref_q[k].sof) nsof++;
    check("sof_count_run1", nsof, 2);

    // ---- same stimulus with random 1..5 cycle gaps ----
    got_q.delete();
    for (int s = 0; s < NTOT; s++) begin
      drive_sample($sformatf("tw_addr_run2[%0d]", s), stim_re[s], stim_im[s], 1'b0, addr_of(s));
      idle($urandom_range(5, 1));
    end
    wait_drain("out_count_gapped", NTOT);
    for (int k = 0; k < NTOT && k < got_q.size() && k < ref_q.size(); k++)
      check($sformatf("gapped_vs_gapfree[%0d]", k), longint'(got_q[k]), longint'(ref_q[k]));

    // ---- reset mid-frame at index 70 ----
    got_q.delete();
    for (int s = 0; s < 70; s++) drive_sample("pre_reset", 1000, 0, 1'b0, -1);
    @(posedge clk); #1;
    di_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_tw_addr", tw_addr, 0);
    check("midrst_do_en", do_en, 0);
    check("midrst_do_sof", do_sof, 0);
    check("midrst_do_re", do_re, 0);
    check("midrst_do_im", do_im, 0);
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    drive_sample("post_rst_tw_addr", 2000, 0, 1'b0, 0);
    idle(1);
    wait_drain("post_rst_count", 1);
    if (got_q.size() > 0) begin
      check("post_rst_re", got_q[0].re, 2000);
      check("post_rst_sof", got_q[0].sof, 1);
    end
    check("hold_do_en", do_en, 0);
    check("hold_do_re", do_re, 2000);
    check("hold_do_im", do_im, 0);

    // ---- frm_clr with di_en at index 50 (index now 1) ----
    got_q.delete();
    for (int s = 1; s < 50; s++) drive_sample("pre_clr", 1000, 0, 1'b0, -1);
    drive_sample("clr_tw_addr", 1000, 0, 1'b1, 0);
    for (int s = 1; s <= 13; s++)
      drive_sample($sformatf("after_clr_tw_addr[%0d]", s), 1000, 0, 1'b0, addr_of(s));
    idle(1);
    wait_drain("clr_count", 63);
    if (got_q.size() >= 63) begin
      check("clr_sample_sof", got_q[49].sof, 1);
      check("clr_next_sof", got_q[50].sof, 0);
      check("clr_idx13_re", got_q[62].re, 999);
      check("clr_idx13_im", got_q[62].im, -44);
    end

    // ---- frm_clr alone (index now 14, address 2) ----
    got_q.delete();
    idle(2);
    @(posedge clk); #1;
    frm_clr = 1'b1;
    di_en   = 1'b0;
    idle(1);
    drive_sample("clr_alone_tw_addr", 1000, 0, 1'b0, 0);
    drive_sample("clr_alone_next_tw_addr", 1000, 0, 1'b0, 0);
    idle(1);
    wait_drain("clr_alone_count", 2);
    if (got_q.size() >= 2) begin
      check("clr_alone_sof", got_q[0].sof, 1);
      check("clr_alone_next_sof", got_q[1].sof, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
